// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - opcodes and FSM state type for the SPI RAM target
package spi_ram_pkg;

    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_QWRITE = 8'h38;
    localparam logic [7:0] CMD_QREAD  = 8'hEB;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_WRITE,
        ST_READ,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/spi_ram_sync.sv
// rtl/spi_ram_sync.sv - 2-FF synchroniser with registered-history edge detect
module spi_ram_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Two flops for metastability, a third holds the previous synchronised level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_prev <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/spi_ram_target.sv
// rtl/spi_ram_target.sv - oversampled SPI/QSPI serial-RAM target; SPI_RAM_TARGET_QSPI_EN enables 0x38/0xEB
module spi_ram_target
    import spi_ram_pkg::*;
#(
    parameter int ADDR_BYTES   = 3,
    parameter int MEM_DEPTH    = 65536,
    parameter int DUMMY_CYCLES = 6,
    parameter int AW           = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          spi_clk,
    input  logic          spi_csb,
    input  logic [3:0]    io_in,
    output logic [3:0]    io_out,
    output logic [3:0]    io_oe,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [7:0]    mem_rdata,
    output logic          busy,
    output logic          cmd_err
);

    localparam int CW = $clog2(8 * ADDR_BYTES + DUMMY_CYCLES + 1);
    localparam logic [CW-1:0] ADDR_LAST_S = CW'(8 * ADDR_BYTES - 1);
    localparam logic [CW-1:0] ADDR_LAST_Q = CW'(2 * ADDR_BYTES - 1);
`ifdef SPI_RAM_TARGET_QSPI_EN
    localparam logic [3:0] IO_MASK = 4'hF;
`else
    localparam logic [3:0] IO_MASK = 4'h3;
`endif

    logic w_sclk_q, w_sclk_rise, w_sclk_fall;
    logic w_csb_q, w_csb_rise, w_csb_fall;

    spi_ram_sync #(.RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .i_async(spi_clk),
        .o_level(w_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_ram_sync #(.RESET_VAL(1'b1)) u_sync_csb (
        .clk(clk), .rst(rst), .i_async(spi_csb),
        .o_level(w_csb_q), .o_rise(w_csb_rise), .o_fall(w_csb_fall)
    );

    logic [3:0]    r_io_meta, r_io_sync;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_ocnt;
    logic [6:0]    r_sh;
    logic [AW-1:0] r_addr, r_maddr;
    logic [7:0]    r_obyte, r_next, r_wdata;
    logic [3:0]    r_oe, r_out;
    logic [1:0]    r_warm;
    logic          r_quad, r_rd, r_armed, r_busy;
    logic          r_we, r_re, r_rd_pend, r_cmd_err;

    logic [7:0]    w_byte;
    logic [AW-1:0] w_addr_next;
    logic [CW-1:0] w_byte_last;
    logic [7:0]    w_src;
    logic [3:0]    w_out_val;

    // Sample shifting: one bit on io[0] in single mode, a full nibble in quad mode
    assign w_byte      = r_quad ? {r_sh[3:0], r_io_sync} : {r_sh[6:0], r_io_sync[0]};
    assign w_addr_next = r_quad ? {r_addr[AW-5:0], r_io_sync} : {r_addr[AW-2:0], r_io_sync[0]};
    assign w_byte_last = r_quad ? CW'(1) : CW'(7);
    // A new output byte starts from the prefetched buffer, later bits from the shifter
    assign w_src       = (r_ocnt == 3'd0) ? r_next : r_obyte;
    assign w_out_val   = r_quad ? w_src[7:4] : {2'b00, w_src[7], 1'b0};

    // Plain 2-FF synchroniser for the IO pads, aligned with the SCLK edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            r_io_meta <= 4'h0;
            r_io_sync <= 4'h0;
        end else begin
            r_io_meta <= io_in;
            r_io_sync <= r_io_meta;
        end
    end

    // Transaction FSM; arming blocks a CSB held low through reset from starting a command
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_ocnt    <= 3'd0;
            r_sh      <= 7'h0;
            r_addr    <= '0;
            r_maddr   <= '0;
            r_obyte   <= 8'h0;
            r_next    <= 8'h0;
            r_wdata   <= 8'h0;
            r_oe      <= 4'h0;
            r_out     <= 4'h0;
            r_warm    <= 2'd0;
            r_quad    <= 1'b0;
            r_rd      <= 1'b0;
            r_armed   <= 1'b0;
            r_busy    <= 1'b0;
            r_we      <= 1'b0;
            r_re      <= 1'b0;
            r_rd_pend <= 1'b0;
            r_cmd_err <= 1'b0;
        end else begin
            r_we      <= 1'b0;
            r_re      <= 1'b0;
            r_cmd_err <= 1'b0;
            r_rd_pend <= r_re;
            if (r_rd_pend) begin
                r_next <= mem_rdata;
            end
            if (r_warm != 2'd3) begin
                r_warm <= r_warm + 2'd1;
            end else if (w_csb_q && !w_sclk_q) begin
                r_armed <= 1'b1;
            end
            r_busy <= r_armed & ~w_csb_q;

            if (w_csb_rise) begin
                r_state <= ST_IDLE;
                r_oe    <= 4'h0;
                r_out   <= 4'h0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_csb_fall && r_armed) begin
                            r_state <= ST_CMD;
                            r_cnt   <= '0;
                            r_ocnt  <= 3'd0;
                            r_quad  <= 1'b0;
                            r_rd    <= 1'b0;
                        end
                    end
                    ST_CMD: begin
                        if (w_sclk_rise) begin
                            r_sh  <= w_byte[6:0];
                            r_cnt <= r_cnt + CW'(1);
                            if (r_cnt == CW'(7)) begin
                                r_cnt   <= '0;
                                r_state <= ST_ADDR;
                                case (w_byte)
                                    CMD_WRITE: r_rd <= 1'b0;
                                    CMD_READ:  r_rd <= 1'b1;
`ifdef SPI_RAM_TARGET_QSPI_EN
                                    CMD_QWRITE: r_quad <= 1'b1;
                                    CMD_QREAD: begin
                                        r_quad <= 1'b1;
                                        r_rd   <= 1'b1;
                                    end
`endif
                                    default: begin
                                        r_state   <= ST_IGNORE;
                                        r_cmd_err <= 1'b1;
                                    end
                                endcase
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (w_sclk_rise) begin
                            r_addr <= w_addr_next;
                            r_cnt  <= r_cnt + CW'(1);
                            if (r_cnt == (r_quad ? ADDR_LAST_Q : ADDR_LAST_S)) begin
                                r_cnt <= '0;
                                if (r_rd) begin
                                    r_re    <= 1'b1;
                                    r_maddr <= w_addr_next;
                                    r_addr  <= w_addr_next + AW'(1);
`ifdef SPI_RAM_TARGET_QSPI_EN
                                    r_state <= (r_quad && DUMMY_CYCLES > 0) ? ST_DUMMY : ST_READ;
`else
                                    r_state <= ST_READ;
`endif
                                end else begin
                                    r_state <= ST_WRITE;
                                end
                            end
                        end
                    end
`ifdef SPI_RAM_TARGET_QSPI_EN
                    ST_DUMMY: begin
                        if (w_sclk_rise) begin
                            r_cnt <= r_cnt + CW'(1);
                            if (r_cnt == CW'(DUMMY_CYCLES - 1)) begin
                                r_cnt   <= '0;
                                r_state <= ST_READ;
                            end
                        end
                    end
`endif
                    ST_WRITE: begin
                        if (w_sclk_rise) begin
                            r_sh  <= w_byte[6:0];
                            r_cnt <= r_cnt + CW'(1);
                            if (r_cnt == w_byte_last) begin
                                r_cnt   <= '0;
                                r_we    <= 1'b1;
                                r_wdata <= w_byte;
                                r_maddr <= r_addr;
                                r_addr  <= r_addr + AW'(1);
                            end
                        end
                    end
                    ST_READ: begin
                        if (w_sclk_fall) begin
                            r_oe    <= (r_quad ? 4'hF : 4'h2) & IO_MASK;
                            r_out   <= w_out_val & IO_MASK;
                            r_obyte <= r_quad ? {w_src[3:0], 4'h0} : {w_src[6:0], 1'b0};
                            r_ocnt  <= (r_ocnt == w_byte_last[2:0]) ? 3'd0 : r_ocnt + 3'd1;
                            if (r_ocnt == 3'd0) begin
                                r_re    <= 1'b1;
                                r_maddr <= r_addr;
                                r_addr  <= r_addr + AW'(1);
                            end
                        end
                    end
                    ST_IGNORE: r_state <= ST_IGNORE;
                    default:   r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign io_out    = r_out;
    assign io_oe     = r_oe;
    assign mem_addr  = r_maddr;
    assign mem_wdata = r_wdata;
    assign mem_we    = r_we;
    assign mem_re    = r_re;
    assign busy      = r_busy;
    assign cmd_err   = r_cmd_err;

endmodule

// File: tb/tb_spi_ram_target.sv
// tb/tb_spi_ram_target.sv - directed self-checking bench for spi_ram_target
module tb_spi_ram_target;

    localparam int HALF = 80;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_clk;
    logic       spi_csb;
    logic [3:0] io_in;
    logic [3:0] io_out;
    logic [3:0] io_oe;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       mem_re;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       cmd_err;

    int         n_checks = 0;
    int         n_fail = 0;
    int         re_cnt = 0;
    int         err_cnt = 0;
    logic [3:0] oe_seen = 4'h0;
    logic [7:0] wa[$];
    logic [7:0] wd[$];
    logic [7:0] mem[256];
    logic [7:0] rx0, rx1, rxd;
    logic [3:0] rnib;

    always #5 clk = ~clk;

    spi_ram_target #(.ADDR_BYTES(3), .MEM_DEPTH(256), .DUMMY_CYCLES(6)) dut (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_csb(spi_csb),
        .io_in(io_in), .io_out(io_out), .io_oe(io_oe),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata), .busy(busy), .cmd_err(cmd_err)
    );

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
        end
        if (mem_re) re_cnt = re_cnt + 1;
        if (cmd_err) err_cnt = err_cnt + 1;
        oe_seen = oe_seen | io_oe;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        re_cnt = 0;
        err_cnt = 0;
        oe_seen = 4'h0;
        wa.delete();
        wd.delete();
    endtask

    task automatic xfer_bit(input logic [3:0] v, output logic [3:0] rx);
        io_in = v;
        #(HALF);
        rx = io_out;
        spi_clk = 1'b1;
        #(HALF);
        spi_clk = 1'b0;
    endtask

    task automatic xfer_byte(input logic [7:0] b, input bit quad, output logic [7:0] rx);
        logic [3:0] r;
        if (quad) begin
            xfer_bit(b[7:4], r);
            rx[7:4] = r;
            xfer_bit(b[3:0], r);
            rx[3:0] = r;
        end else begin
            for (int i = 7; i >= 0; i--) begin
                xfer_bit({3'b000, b[i]}, r);
                rx[i] = r[1];
            end
        end
    endtask

    task automatic cs_low();
        spi_csb = 1'b0;
        #(HALF);
    endtask

    task automatic cs_high();
        #(HALF);
        spi_csb = 1'b1;
        #(HALF * 2);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem_rdata = 8'h00;
        rst = 1'b1;
        spi_csb = 1'b0;
        spi_clk = 1'b0;
        io_in = 4'h0;

        // reset held while CSB low and SCLK toggling
        repeat (3) begin
            #40 spi_clk = 1'b1;
            #40 spi_clk = 1'b0;
        end
        @(negedge clk);
        check("rst_io_oe", io_oe, 4'h0);
        check("rst_io_out", io_out, 4'h0);
        check("rst_mem_addr", mem_addr, 8'h00);
        check("rst_mem_wdata", mem_wdata, 8'h00);
        check("rst_we_re", {mem_we, mem_re}, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_cmd_err", cmd_err, 1'b0);

        // release reset with CSB still low: nothing may happen
        rst = 1'b0;
        clear_mon();
        xfer_byte(8'h02, 1'b0, rxd);
        xfer_byte(8'h00, 1'b0, rxd);
        xfer_byte(8'h10, 1'b0, rxd);
        xfer_byte(8'hA5, 1'b0, rxd);
        check("postrst_busy", busy, 1'b0);
        check("postrst_we", wa.size(), 0);
        check("postrst_re", re_cnt, 0);
        check("postrst_oe", oe_seen, 4'h0);
        spi_clk = 1'b0;
        cs_high();

        // single write 0x02 @0x10 : A5 5A
        clear_mon();
        cs_low();
        xfer_byte(8'h02, 1'b0, rxd);
        xfer_byte(8'h00, 1'b0, rxd);
        xfer_byte(8'h00, 1'b0, rxd);
        xfer_byte(8'h10, 1'b0, rxd);
        check("wr_busy", busy, 1'b1);
        xfer_byte(8'hA5, 1'b0, rxd);
        xfer_byte(8'h5A, 1'b0, rxd);
        cs_high();
        check("wr_count", wa.size(), 2);
        check("wr_0", {wa[0], wd[0]}, 16'h10A5);
        check("wr_1", {wa[1], wd[1]}, 16'h115A);
        check("wr_oe", oe_seen, 4'h0);
        check("wr_busy_end", busy, 1'b0);

        // single read 0x03 @0x10
        clear_mon();
        cs_low();
        xfer_byte(8'h03, 1'b0, rxd);
        xfer_byte(8'h00, 1'b0, rxd);
        xfer_byte(8'h00, 1'b0, rxd);
        xfer_byte(8'h10, 1'b0, rxd);
        check("rd_oe_addr", oe_seen, 4'h0);
        xfer_byte(8'h00, 1'b0, rx0);
        check("rd_oe_data", io_oe, 4'h2);
        xfer_byte(8'h00, 1'b0, rx1);
        cs_high();
        check("rd_byte0", rx0, 8'hA5);
        check("rd_byte1", rx1, 8'h5A);
        check("rd_re_count", re_cnt, 4);
        check("rd_no_we", wa.size(), 0);
        check("rd_oe_end", io_oe, 4'h0);

        // wrap at MEM_DEPTH-1
        clear_mon();
        cs_low();
        xfer_byte(8'h02, 1'b0, rxd);
        xfer_byte(8'h00, 1'b0, rxd);
        xfer_byte(8'h00, 1'b0, rxd);
        xfer_byte(8'hFF, 1'b0, rxd);
        xfer_byte(8'h11, 1'b0, rxd);
        xfer_byte(8'h22, 1'b0, rxd);
        cs_high();
        check("wrap_count", wa.size(), 2);
        check("wrap_0", {wa[0], wd[0]}, 16'hFF11);
        check("wrap_1", {wa[1], wd[1]}, 16'h0022);

`ifdef SPI_RAM_TARGET_QSPI_EN
        // quad read 0xEB @0x10 with 6 dummy clocks
        clear_mon();
        cs_low();
        xfer_byte(8'hEB, 1'b0, rxd);
        xfer_byte(8'h00, 1'b1, rxd);
        xfer_byte(8'h00, 1'b1, rxd);
        xfer_byte(8'h10, 1'b1, rxd);
        check("qrd_oe_addr", oe_seen, 4'h0);
        repeat (6) xfer_bit(4'h0, rnib);
        check("qrd_oe_dummy", oe_seen, 4'h0);
        xfer_byte(8'h00, 1'b1, rx0);
        check("qrd_oe_data", io_oe, 4'hF);
        xfer_byte(8'h00, 1'b1, rx1);
        cs_high();
        check("qrd_byte0", rx0, 8'hA5);
        check("qrd_byte1", rx1, 8'h5A);
        check("qrd_err", err_cnt, 0);
`else
        // quad read opcode without quad support
        clear_mon();
        cs_low();
        xfer_byte(8'hEB, 1'b0, rxd);
        xfer_byte(8'h00, 1'b0, rxd);
        xfer_byte(8'h00, 1'b0, rxd);
        xfer_byte(8'h10, 1'b0, rxd);
        xfer_byte(8'h00, 1'b0, rxd);
        cs_high();
        check("qrd_off_err", err_cnt, 1);
        check("qrd_off_re", re_cnt, 0);
        check("qrd_off_oe", oe_seen, 4'h0);
`endif

        // unsupported opcode 0x9F
        clear_mon();
        cs_low();
        xfer_byte(8'h9F, 1'b0, rxd);
        xfer_byte(8'h00, 1'b0, rxd);
        xfer_byte(8'h00, 1'b0, rxd);
        cs_high();
        check("bad_err", err_cnt, 1);
        check("bad_re", re_cnt, 0);
        check("bad_we", wa.size(), 0);
        check("bad_oe", oe_seen, 4'h0);

        // CSB rise mid-byte discards the partial byte
        clear_mon();
        cs_low();
        xfer_byte(8'h02, 1'b0, rxd);
        xfer_byte(8'h00, 1'b0, rxd);
        xfer_byte(8'h00, 1'b0, rxd);
        xfer_byte(8'h20, 1'b0, rxd);
        xfer_byte(8'h77, 1'b0, rxd);
        repeat (4) xfer_bit(4'h1, rnib);
        cs_high();
        check("part_count", wa.size(), 1);
        check("part_0", {wa[0], wd[0]}, 16'h2077);
        check("part_mem21", mem[8'h21], 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_ram_target.md
# spi_ram_target

Synthesizable, oversampled SPI/QSPI RAM target for on-chip test harnesses: it presents a serial-RAM command set on a four-wire IO bus and maps accesses onto a generic single-port byte memory interface. All SPI signals are sampled in the system clock domain, so the block is a timing-clean replacement for the behavioural serial-RAM model on FPGA/SoC benches. Address width, memory depth and read latency are parameters; quad-mode commands are compile-time optional.

## Interface
- ADDR_BYTES, 3: address bytes per command (2 or 3).
- MEM_DEPTH, 65536: memory bytes, power of two; address wraps modulo MEM_DEPTH.
- DUMMY_CYCLES, 6: SCLK cycles between address and data for quad read (0xEB).
- AW, $clog2(MEM_DEPTH): derived, memory address width.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- spi_clk  in  1  SPI clock (mode 0), asynchronous.
- spi_csb  in  1  chip select, active low, asynchronous.
- io_in  in  4  IO pad inputs, io_in[0]=MOSI, io_in[1]=MISO.
- io_out  out  4  IO pad output values.
- io_oe  out  4  IO pad output enables.
- mem_addr  out  AW  byte address.
- mem_wdata  out  8  write data.
- mem_we  out  1  one-cycle write strobe.
- mem_re  out  1  one-cycle read strobe.
- mem_rdata  in  8  read data, valid exactly one clk after mem_re.
- busy  out  1  high while a transaction is selected.
- cmd_err  out  1  one-cycle pulse on unsupported opcode.

## Operation
- spi_clk, spi_csb, io_in pass through 2-FF synchronisers; rising/falling SCLK and CSB edges detected from synchronised values.
- Mode 0: input sampled on SCLK rise, output updated on SCLK fall. MSB first; quad nibbles {io3,io2,io1,io0}, high nibble first.
- States: IDLE, CMD, ADDR, DUMMY, WRITE, READ, IGNORE.
  - IDLE -> CMD on CSB fall. CMD shifts 8 single-bit samples.
  - 0x02 write, 0x03 read: single-bit ADDR (8*ADDR_BYTES bits), then WRITE/READ.
  - 0x38 quad write: quad ADDR, then WRITE in quad.
  - 0xEB quad read: quad ADDR, DUMMY for DUMMY_CYCLES SCLK rises (io_oe=0), then READ in quad.
  - Other opcode: cmd_err pulse, IGNORE until CSB rise.
  - Any state -> IDLE on CSB rise; io_oe=0 in the same clk.
- Address: upper bits beyond AW ignored; increments by 1 after each byte, wraps MEM_DEPTH-1 -> 0.
- WRITE: on each completed byte, mem_we=1 for one clk with current address. Partial byte at CSB rise discarded.
- READ: mem_re issued when address completes (and after each byte is loaded into the shift register) to prefetch next byte; io_oe = 4'b0010 (single) or 4'b1111 (quad) from first SCLK fall after address/dummy until CSB rise.
- Unused IO: io_oe=0, io_out=0.

## Timing
- Reset: state IDLE, io_oe=0, io_out=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, busy=0, cmd_err=0; synchroniser CSB=1, SCLK=0. Reset mid-transaction aborts it; next transaction starts only on a fresh CSB fall.
- Edge-to-action latency: 3 clk (2 sync + 1 detect).
- Requirement: SCLK high and low phases each >= 4 clk; CSB setup/hold to SCLK >= 4 clk. Outside this, behaviour undefined.
- Read prefetch: mem_re at address completion; data latched into shift register 1 clk later; ready before next SCLK fall.
- mem_we asserted 1 clk after the completing SCLK-rise detection. busy follows synchronised CSB (3 clk lag).
- CSB rise and SCLK rise detected in the same clk: CSB wins, sample discarded.

## Configuration
- SPI_RAM_TARGET_QSPI_EN defined: 0x38 and 0xEB supported, io_oe[3:2] usable.
- Undefined: 0x38/0xEB raise cmd_err and go to IGNORE; io_oe[3:2], io_out[3:2] tied 0; DUMMY state and counter removed.

## Structure
- Package spi_ram_pkg: opcode constants (CMD_WRITE=0x02, CMD_READ=0x03, CMD_QWRITE=0x38, CMD_QREAD=0xEB), state enum type.
- Sub-module spi_ram_sync: 2-FF synchroniser plus rise/fall detect, instantiated for spi_clk and spi_csb; io_in uses plain 2-FF sync.

## Test plan
- Reset with CSB low and SCLK toggling -> io_oe=0, no mem strobes until CSB goes high then low.
- 0x02, addr 0x000010, data 0xA5 0x5A -> mem_we at 0x0010=0xA5, 0x0011=0x5A; io_oe stays 0.
- 0x03, addr 0x000010 after above -> MISO returns 0xA5 then 0x5A; io_oe=4'b0010 during data only.
- MEM_DEPTH=256, 0x02 at 0xFF with 2 bytes -> writes 0xFF then 0x00 (wrap).
- 0xEB, addr 0x000010, 6 dummy clocks -> io_oe=0 in dummy, then nibbles A,5,5,A on io[3:0]; with macro off -> cmd_err pulse, no mem_re.
- Opcode 0x9F -> one cmd_err pulse, no strobes; CSB rise mid-byte of 0x02 data -> partial byte not written.
